// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with redirect handling
//
// Purpose: issues word-aligned reads to instruction memory, presents one
// fetched instruction at a time to the decoder, and follows redirects
// (taken branch / JAL / JALR). All outputs are registered.
//
// Ports:
//   CLK, RST                     clock, asynchronous active-high reset
//   imem_req, imem_addr          read request and byte address (held until ack)
//   imem_ack, imem_rdata         one-cycle acknowledge with returned word
//   Inst, inst_pc, inst_valid    instruction to decoder, its address, valid
//   inst_ready                   decoder consumes Inst this cycle
//   redirect, redirect_pc        fetch-stream change and new target
//   misalign_err                 sticky misaligned-target flag
//
// Build option: FETCH_MISALIGN_TRAP_EN - when defined, a redirect to a
// non-word-aligned target enters ERR and sets misalign_err; when undefined
// the low two target bits are cleared and misalign_err is constant 0.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        HOLD = 3'd2,
        DROP = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        misalign_err_q, misalign_err_d;
    logic [31:0] tgt_q, tgt_d;          // redirect target waiting for the dropped ack
    logic        tgt_bad_q, tgt_bad_d;  // that target is misaligned

    logic [31:0] tgt_pc;
    logic        tgt_bad;
    logic        ack_v;
    logic        jump;
    logic [31:0] jump_pc;
    logic        jump_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt_pc       = redirect_pc;
    assign tgt_bad      = |redirect_pc[1:0];
    assign misalign_err = misalign_err_q;
`else
    logic unused_bits;
    assign tgt_pc       = {redirect_pc[31:2], 2'b00};
    assign tgt_bad      = 1'b0;
    assign misalign_err = 1'b0;
    assign unused_bits  = ^{redirect_pc[1:0], misalign_err_q};
`endif

    // An ack is only honoured against a request we actually have outstanding;
    // this also discards a late ack for a request cut short by reset.
    assign ack_v = imem_ack & imem_req_q;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        imem_req_d     = imem_req_q;
        imem_addr_d    = imem_addr_q;
        inst_d         = inst_q;
        inst_pc_d      = inst_pc_q;
        inst_valid_d   = inst_valid_q;
        misalign_err_d = misalign_err_q;
        tgt_d          = tgt_q;
        tgt_bad_d      = tgt_bad_q;
        jump           = 1'b0;
        jump_pc        = tgt_pc;
        jump_bad       = tgt_bad;

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    jump = 1'b1;
                end else begin
                    // Request is raised one cycle after entering REQ.
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    if (ack_v || !imem_req_q) begin
                        jump = 1'b1;
                    end else begin
                        // Bus request must stay stable until its ack: park the target.
                        tgt_d     = tgt_pc;
                        tgt_bad_d = tgt_bad;
                        state_d   = DROP;
                    end
                end else if (ack_v) begin
                    inst_d       = imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + 32'd4;
                    imem_req_d   = 1'b0;
                    state_d      = HOLD;
                end else if (!imem_req_q) begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                end
            end
            HOLD: begin
                if (redirect) begin
                    jump = 1'b1;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    inst_d       = NOP_INST;
                    imem_req_d   = 1'b1;
                    imem_addr_d  = pc_q;
                    state_d      = REQ;
                end
            end
            DROP: begin
                if (redirect) begin
                    tgt_d     = tgt_pc;
                    tgt_bad_d = tgt_bad;
                end
                if (ack_v) begin
                    jump = 1'b1;
                    // A redirect arriving with the ack is the newest target.
                    if (!redirect) begin
                        jump_pc  = tgt_q;
                        jump_bad = tgt_bad_q;
                    end
                end
            end
            ERR: begin
                imem_req_d     = 1'b0;
                inst_valid_d   = 1'b0;
                misalign_err_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (jump) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
            if (jump_bad) begin
                imem_req_d     = 1'b0;
                misalign_err_d = 1'b1;
                state_d        = ERR;
            end else begin
                pc_d        = jump_pc;
                imem_req_d  = 1'b1;
                imem_addr_d = jump_pc;
                state_d     = REQ;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            imem_req_q     <= 1'b0;
            imem_addr_q    <= RESET_PC;
            inst_q         <= NOP_INST;
            inst_pc_q      <= 32'h0;
            inst_valid_q   <= 1'b0;
            misalign_err_q <= 1'b0;
            tgt_q          <= 32'h0;
            tgt_bad_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            imem_req_q     <= imem_req_d;
            imem_addr_q    <= imem_addr_d;
            inst_q         <= inst_d;
            inst_pc_q      <= inst_pc_d;
            inst_valid_q   <= inst_valid_d;
            misalign_err_q <= misalign_err_d;
            tgt_q          <= tgt_d;
            tgt_bad_q      <= tgt_bad_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign Inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit

module tb_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    fetch_unit dut (
        .CLK          (CLK),
        .RST          (RST),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .Inst         (Inst),
        .inst_pc      (inst_pc),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .misalign_err (misalign_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } inst_t;

    logic [31:0] exp_addr_q[$];
    inst_t       exp_inst_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    // Monitor: samples 1ns before each rising edge.
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] e_addr;
    inst_t       e_inst;

    always @(negedge CLK) begin
        #4;
        if (!RST) begin
            if (imem_req && imem_ack) begin
                if (exp_addr_q.size() == 0) fail_now("unexpected_ack");
                else begin
                    e_addr = exp_addr_q.pop_front();
                    check32("ack_addr", imem_addr, e_addr);
                end
            end
            if (inst_valid && inst_ready) begin
                if (exp_inst_q.size() == 0) fail_now("unexpected_consume");
                else begin
                    e_inst = exp_inst_q.pop_front();
                    check32("consume_inst", Inst, e_inst.inst);
                    check32("consume_pc", inst_pc, e_inst.pc);
                end
            end
            if (prev_req && !prev_ack) begin
                check32("req_held", {31'h0, imem_req}, 32'h1);
                check32("addr_stable", imem_addr, prev_addr);
            end
        end
        prev_req  = imem_req && !RST;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
    end

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!imem_req && n < 10) begin
            cyc();
            n++;
        end
        if (!imem_req) fail_now("wait_req_timeout");
    endtask

    // Acks the outstanding request after nwait idle cycles; returns in the
    // cycle following the ack with imem_ack low again.
    task automatic do_ack(input int nwait, input logic [31:0] data);
        wait_req();
        imem_ack = 1'b0;
        for (int i = 0; i < nwait; i++) cyc();
        imem_ack   = 1'b1;
        imem_rdata = data;
        cyc();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic consume();
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] hold_inst;
        logic [31:0] hold_pc;
        RST         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) cyc();

        check32("rst_req", {31'h0, imem_req}, 32'h0);
        check32("rst_addr", imem_addr, 32'h0);
        check32("rst_inst", Inst, 32'h0000_0013);
        check32("rst_inst_pc", inst_pc, 32'h0);
        check32("rst_valid", {31'h0, inst_valid}, 32'h0);
        check32("rst_err", {31'h0, misalign_err}, 32'h0);

        RST = 1'b0;
        cyc();
        check32("first_edge_no_req", {31'h0, imem_req}, 32'h0);
        cyc();
        check32("second_edge_req", {31'h0, imem_req}, 32'h1);
        check32("second_edge_addr", imem_addr, 32'h0);

        // First fetch, two wait cycles
        exp_addr_q.push_back(32'h0);
        exp_inst_q.push_back('{inst: 32'h0050_0093, pc: 32'h0});
        do_ack(2, 32'h0050_0093);
        check32("t1_valid", {31'h0, inst_valid}, 32'h1);
        check32("t1_inst", Inst, 32'h0050_0093);
        check32("t1_pc", inst_pc, 32'h0);

        // Decoder stall for 5 cycles
        hold_inst = Inst;
        hold_pc   = inst_pc;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check32("stall_inst", Inst, hold_inst);
            check32("stall_pc", inst_pc, hold_pc);
            check32("stall_no_req", {31'h0, imem_req}, 32'h0);
        end
        consume();
        check32("t2_req", {31'h0, imem_req}, 32'h1);
        check32("t2_addr", imem_addr, 32'h4);
        exp_addr_q.push_back(32'h4);
        exp_inst_q.push_back('{inst: 32'hAAAA_0001, pc: 32'h4});
        do_ack(0, 32'hAAAA_0001);
        consume();

        // Redirect during REQ at 0x8, ack three cycles later
        check32("t3_addr_before", imem_addr, 32'h8);
        exp_addr_q.push_back(32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        cyc();
        cyc();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_ack = 1'b0;
        check32("t3_dropped", {31'h0, inst_valid}, 32'h0);
        check32("t3_req", {31'h0, imem_req}, 32'h1);
        check32("t3_new_addr", imem_addr, 32'h100);
        exp_addr_q.push_back(32'h100);
        exp_inst_q.push_back('{inst: 32'h0010_0113, pc: 32'h100});
        do_ack(1, 32'h0010_0113);
        consume();

        // Same-cycle redirect and ack at 0x104
        exp_addr_q.push_back(32'h104);
        wait_req();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        imem_ack    = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        cyc();
        redirect = 1'b0;
        imem_ack = 1'b0;
        check32("t4_valid", {31'h0, inst_valid}, 32'h0);
        check32("t4_addr", imem_addr, 32'h40);
        exp_addr_q.push_back(32'h40);
        exp_inst_q.push_back('{inst: 32'h0000_0513, pc: 32'h40});
        do_ack(0, 32'h0000_0513);

        // Redirect together with ready in HOLD, into the wrap address
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        inst_ready = 1'b0;
        redirect   = 1'b0;
        check32("t5_addr", imem_addr, 32'hFFFF_FFFC);
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_inst_q.push_back('{inst: 32'h0000_006F, pc: 32'hFFFF_FFFC});
        do_ack(0, 32'h0000_006F);
        check32("t5_inst_pc", inst_pc, 32'hFFFF_FFFC);
        consume();
        check32("t5_wrap_addr", imem_addr, 32'h0);
        exp_addr_q.push_back(32'h0);
        exp_inst_q.push_back('{inst: 32'h1234_5678, pc: 32'h0});
        do_ack(0, 32'h1234_5678);
        consume();

        // Misaligned redirect from HOLD (held instruction not consumed)
        exp_addr_q.push_back(32'h4);
        do_ack(0, 32'h9999_9999);
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        cyc();
        redirect = 1'b0;
        check32("t6_valid", {31'h0, inst_valid}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check32("t6_err", {31'h0, misalign_err}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            check32("t6_no_req", {31'h0, imem_req}, 32'h0);
            cyc();
        end
        check32("t6_err_sticky", {31'h0, misalign_err}, 32'h1);
`else
        check32("t6_req", {31'h0, imem_req}, 32'h1);
        check32("t6_addr", imem_addr, 32'h100);
        check32("t6_no_err", {31'h0, misalign_err}, 32'h0);
        exp_addr_q.push_back(32'h100);
        exp_inst_q.push_back('{inst: 32'h0000_0073, pc: 32'h100});
        do_ack(0, 32'h0000_0073);
        consume();
`endif

        // Reset mid-stream: request drops at once, later ack ignored
        RST = 1'b1;
        #1;
        check32("rst_async_req", {31'h0, imem_req}, 32'h0);
        check32("rst_async_err", {31'h0, misalign_err}, 32'h0);
        cyc();
        RST = 1'b0;
        cyc();
        check32("rst2_no_req", {31'h0, imem_req}, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hFEED_F00D;
        cyc();
        imem_ack = 1'b0;
        check32("rst2_ack_ignored", {31'h0, inst_valid}, 32'h0);
        check32("rst2_req", {31'h0, imem_req}, 32'h1);
        check32("rst2_addr", imem_addr, 32'h0);
        exp_addr_q.push_back(32'h0);
        exp_inst_q.push_back('{inst: 32'h0000_1111, pc: 32'h0});
        do_ack(0, 32'h0000_1111);
        consume();
        cyc();
        cyc();

        check32("addr_q_drained", exp_addr_q.size(), 32'h0);
        check32("inst_q_drained", exp_inst_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
